// File: rtl/cv32e40x_uop_sequencer.sv
// ============================================================================
// cv32e40x_uop_sequencer : expands Zcmp push/pop into RV32I micro-ops and
// passes every other instruction through. Zcmp gated by CV32E40X_ZCMP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cv32e40x_uop_sequencer #(
  parameter int RLIST_MAX   = 15,
  parameter int STACK_ALIGN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  output logic        instr_ready_o,
  input  logic        kill_i,
  output logic        uop_valid_o,
  input  logic        uop_ready_i,
  output logic [31:0] uop_instr_o,
  output logic        uop_first_o,
  output logic        uop_last_o,
  output logic        uop_illegal_o,
  output logic        seq_active_o
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEQ = 1'b1} state_e;

  localparam logic [1:0]  c_OP_PUSH    = 2'b00;
  localparam logic [1:0]  c_OP_POP     = 2'b01;
  localparam logic [1:0]  c_OP_POPRETZ = 2'b10;
  localparam logic [4:0]  c_SP         = 5'd2;
  localparam logic [31:0] c_LI_A0      = 32'h0000_0513;
  localparam logic [31:0] c_RET        = 32'h0000_8067;
  localparam logic [3:0]  c_RLIST_MAX  = 4'(RLIST_MAX);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  rlist_q, rlist_d;
  logic [1:0]  spimm_q, spimm_d;
  logic        valid_q, valid_d;
  logic [31:0] uinstr_q, uinstr_d;
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic        illegal_q, illegal_d;

  logic        w_is_zcmp;
  logic        w_illegal;
  logic        w_uop_acc;
  logic        w_instr_acc;
  logic [32:0] w_new_uop;
  logic [32:0] w_seq_uop;

  // Micro-op k of a Zcmp instruction, returned as {last, encoding}.
  function automatic logic [32:0] f_uop(input logic [1:0] op, input logic [3:0] rlist,
                                        input logic [1:0] spimm, input logic [4:0] k);
    logic [4:0]  n;
    logic [4:0]  j;
    logic [4:0]  rnum;
    logic [11:0] adj;
    logic [11:0] ofs;
    logic [11:0] imm;
    logic [31:0] ins;
    logic        last;
    n = (rlist == 4'd15) ? 5'd13 : ({1'b0, rlist} - 5'd3);
    case (rlist[3:2])
      2'b01:   adj = 12'd16;
      2'b10:   adj = 12'd32;
      default: adj = (rlist == 4'd15) ? 12'd64 : 12'd48;
    endcase
    adj = adj + 12'(spimm) * 12'(STACK_ALIGN);
    // Registers are stored highest-first: list index N-1-k.
    j = n - 5'd1 - k;
    case (j)
      5'd0:    rnum = 5'd1;
      5'd1:    rnum = 5'd8;
      5'd2:    rnum = 5'd9;
      default: rnum = j + 5'd15;
    endcase
    ofs  = {5'd0, k + 5'd1, 2'b00};
    imm  = 12'd0;
    ins  = c_RET;
    last = 1'b1;
    if (k < n) begin
      last = 1'b0;
      if (op == c_OP_PUSH) begin
        imm = 12'd0 - ofs;
        ins = {imm[11:5], rnum, c_SP, 3'b010, imm[4:0], 7'b0100011};
      end else begin
        imm = adj - ofs;
        ins = {imm, c_SP, 3'b010, rnum, 7'b0000011};
      end
    end else if (k == n) begin
      imm  = (op == c_OP_PUSH) ? (12'd0 - adj) : adj;
      ins  = {imm, c_SP, 3'b000, c_SP, 7'b0010011};
      last = (op == c_OP_PUSH) || (op == c_OP_POP);
    end else if ((k == n + 5'd1) && (op == c_OP_POPRETZ)) begin
      ins  = c_LI_A0;
      last = 1'b0;
    end
    return {last, ins};
  endfunction

`ifdef CV32E40X_ZCMP_EN
  // B8/BA/BC/BE in [15:8]; the op is carried in bits [10:9].
  assign w_is_zcmp = (instr_i[1:0] == 2'b10) && (instr_i[15:11] == 5'b10111) && !instr_i[8];
`else
  assign w_is_zcmp = 1'b0;
`endif

  assign w_illegal   = (instr_i[7:4] < 4'd4) || (instr_i[7:4] > c_RLIST_MAX);
  assign w_uop_acc   = valid_q && uop_ready_i;
  assign instr_ready_o = (state_q == S_IDLE) && !kill_i && (!valid_q || uop_ready_i);
  assign w_instr_acc = instr_valid_i && instr_ready_o;
  assign w_new_uop   = f_uop(instr_i[10:9], instr_i[7:4], instr_i[3:2], 5'd0);
  assign w_seq_uop   = f_uop(op_q, rlist_q, spimm_q, cnt_q + 5'd1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rlist_d   = rlist_q;
    spimm_d   = spimm_q;
    valid_d   = valid_q;
    uinstr_d  = uinstr_q;
    first_d   = first_q;
    last_d    = last_q;
    illegal_d = illegal_q;
    if (kill_i) begin
      valid_d = 1'b0;
      state_d = S_IDLE;
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_uop_acc) valid_d = 1'b0;
          if (w_instr_acc) begin
            valid_d = 1'b1;
            first_d = 1'b1;
            cnt_d   = 5'd0;
            if (w_is_zcmp && !w_illegal) begin
              state_d   = S_SEQ;
              op_d      = instr_i[10:9];
              rlist_d   = instr_i[7:4];
              spimm_d   = instr_i[3:2];
              last_d    = w_new_uop[32];
              uinstr_d  = w_new_uop[31:0];
              illegal_d = 1'b0;
            end else begin
              uinstr_d  = instr_i;
              last_d    = 1'b1;
              illegal_d = w_is_zcmp;
            end
          end
        end
        S_SEQ: begin
          if (w_uop_acc) begin
            if (last_q) begin
              valid_d = 1'b0;
              state_d = S_IDLE;
              cnt_d   = 5'd0;
            end else begin
              cnt_d    = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
              first_d  = 1'b0;
              last_d   = w_seq_uop[32];
              uinstr_d = w_seq_uop[31:0];
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      op_q      <= 2'b00;
      rlist_q   <= 4'd0;
      spimm_q   <= 2'b00;
      valid_q   <= 1'b0;
      uinstr_q  <= 32'd0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rlist_q   <= rlist_d;
      spimm_q   <= spimm_d;
      valid_q   <= valid_d;
      uinstr_q  <= uinstr_d;
      first_q   <= first_d;
      last_q    <= last_d;
      illegal_q <= illegal_d;
    end
  end

  assign uop_valid_o   = valid_q;
  assign uop_instr_o   = uinstr_q;
  assign uop_first_o   = first_q;
  assign uop_last_o    = last_q;
  assign uop_illegal_o = illegal_q;
  assign seq_active_o  = (state_q == S_SEQ);

endmodule

`default_nettype wire

// File: tb/tb_cv32e40x_uop_sequencer.sv
// ============================================================================
// tb_cv32e40x_uop_sequencer : directed and random stimulus against a
// list-based expansion model of the Zcmp micro-op sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cv32e40x_uop_sequencer;

  localparam int RLIST_MAX   = 15;
  localparam int STACK_ALIGN = 16;
`ifdef CV32E40X_ZCMP_EN
  localparam bit ZCMP = 1'b1;
`else
  localparam bit ZCMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid_i = 1'b0;
  logic [31:0] instr_i = 32'd0;
  logic        instr_ready_o;
  logic        kill_i = 1'b0;
  logic        uop_valid_o;
  logic        uop_ready_i = 1'b0;
  logic [31:0] uop_instr_o;
  logic        uop_first_o;
  logic        uop_last_o;
  logic        uop_illegal_o;
  logic        seq_active_o;

  cv32e40x_uop_sequencer #(.RLIST_MAX(RLIST_MAX), .STACK_ALIGN(STACK_ALIGN)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid_i (instr_valid_i),
    .instr_i       (instr_i),
    .instr_ready_o (instr_ready_o),
    .kill_i        (kill_i),
    .uop_valid_o   (uop_valid_o),
    .uop_ready_i   (uop_ready_i),
    .uop_instr_o   (uop_instr_o),
    .uop_first_o   (uop_first_o),
    .uop_last_o    (uop_last_o),
    .uop_illegal_o (uop_illegal_o),
    .seq_active_o  (seq_active_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] ins;
    logic        first;
    logic        last;
    logic        ill;
    logic        multi;
  } uop_t;

  uop_t        mq[$];
  logic [31:0] xlog[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic uop_t mk(input logic [31:0] ins, input logic ill, input logic multi);
    uop_t u;
    u.ins = ins; u.first = 1'b1; u.last = 1'b1; u.ill = ill; u.multi = multi;
    return u;
  endfunction

  function automatic logic [31:0] enc_sw(input int rs, input int imm);
    logic [11:0] i; logic [4:0] r;
    i = imm[11:0]; r = rs[4:0];
    return {i[11:5], r, 5'd2, 3'b010, i[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_lw(input int rd, input int imm);
    logic [11:0] i; logic [4:0] r;
    i = imm[11:0]; r = rd[4:0];
    return {i, 5'd2, 3'b010, r, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_addi_sp(input int imm);
    logic [11:0] i;
    i = imm[11:0];
    return {i, 5'd2, 3'b000, 5'd2, 7'b0010011};
  endfunction

  // Appends the full expected micro-op list of one accepted instruction.
  function automatic void expand(input logic [31:0] ins);
    int   regs[13] = '{1, 8, 9, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27};
    uop_t tmp[$];
    uop_t u;
    int   rl, sp, n, base, adj;
    logic [7:0] opb;
    opb = ins[15:8];
    if (!ZCMP || ins[1:0] != 2'b10 || !(opb inside {8'hB8, 8'hBA, 8'hBC, 8'hBE})) begin
      mq.push_back(mk(ins, 1'b0, 1'b0));
      return;
    end
    rl = int'(ins[7:4]);
    sp = int'(ins[3:2]);
    if (rl < 4 || rl > RLIST_MAX) begin
      mq.push_back(mk(ins, 1'b1, 1'b0));
      return;
    end
    n    = (rl == 15) ? 13 : rl - 3;
    base = (rl <= 7) ? 16 : (rl <= 11) ? 32 : (rl <= 14) ? 48 : 64;
    adj  = base + sp * STACK_ALIGN;
    for (int k = 0; k < n; k++) begin
      if (opb == 8'hB8) tmp.push_back(mk(enc_sw(regs[n-1-k], -4 * (k + 1)), 1'b0, 1'b1));
      else              tmp.push_back(mk(enc_lw(regs[n-1-k], adj - 4 * (k + 1)), 1'b0, 1'b1));
    end
    tmp.push_back(mk(enc_addi_sp(opb == 8'hB8 ? -adj : adj), 1'b0, 1'b1));
    if (opb == 8'hBC) tmp.push_back(mk(32'h0000_0513, 1'b0, 1'b1));
    if (opb == 8'hBC || opb == 8'hBE) tmp.push_back(mk(32'h0000_8067, 1'b0, 1'b1));
    for (int i = 0; i < tmp.size(); i++) begin
      u = tmp[i];
      u.first = (i == 0);
      u.last  = (i == tmp.size() - 1);
      mq.push_back(u);
    end
  endfunction

  // One clock: drive at negedge, check before posedge, advance model after it.
  task automatic step(input logic v, input logic [31:0] ins, input logic rdy,
                      input logic kl, output logic acc);
    logic exp_rdy, seq, xfer;
    @(negedge clk);
    instr_valid_i = v; instr_i = ins; uop_ready_i = rdy; kill_i = kl;
    #1;
    seq     = (mq.size() > 0) && mq[0].multi;
    exp_rdy = !kl && !seq && ((mq.size() == 0) || rdy);
    chk("instr_ready", 32'(instr_ready_o), 32'(exp_rdy));
    chk("uop_valid", 32'(uop_valid_o), 32'(mq.size() > 0));
    chk("seq_active", 32'(seq_active_o), 32'(seq));
    if (mq.size() > 0) begin
      chk("uop_instr", uop_instr_o, mq[0].ins);
      chk("uop_first", 32'(uop_first_o), 32'(mq[0].first));
      chk("uop_last", 32'(uop_last_o), 32'(mq[0].last));
      chk("uop_illegal", 32'(uop_illegal_o), 32'(mq[0].ill));
    end
    xfer = (mq.size() > 0) && rdy && !kl;
    if (xfer) xlog.push_back(uop_instr_o);
    acc = v && exp_rdy;
    @(posedge clk);
    if (kl) mq.delete();
    else begin
      if (xfer) void'(mq.pop_front());
      if (acc) expand(ins);
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic rdy);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) step(1'b1, ins, rdy, 1'b0, acc);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 40 && mq.size() > 0; i++) step(1'b0, 32'd0, 1'b1, 1'b0, acc);
    step(1'b0, 32'd0, 1'b1, 1'b0, acc);
  endtask

  task automatic chk_reset_state();
    chk("rst_valid", 32'(uop_valid_o), 32'd0);
    chk("rst_instr", uop_instr_o, 32'd0);
    chk("rst_first", 32'(uop_first_o), 32'd0);
    chk("rst_last", 32'(uop_last_o), 32'd0);
    chk("rst_illegal", 32'(uop_illegal_o), 32'd0);
    chk("rst_seq", 32'(seq_active_o), 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       r[1:0] = 2'b11;
      1, 2:    r[15:0] = {5'b10111, 2'($urandom_range(0, 3)), 1'b0, 4'($urandom_range(4, 15)),
                          2'($urandom), 2'b10};
      default: r[1:0] = 2'b10;
    endcase
    return r;
  endfunction

  initial begin
    logic acc;
    #2 rst = 1'b1;
    #1 chk_reset_state();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Passthrough, back to back.
    send(32'h00A0_0093, 1'b1);
    send(32'h0010_0113, 1'b1);
    drain();

    // cm.push {ra,s0-s1},-16
    xlog.delete();
    send(32'h0000_B862, 1'b1);
    drain();
`ifdef CV32E40X_ZCMP_EN
    chk("push_len", 32'(xlog.size()), 32'd4);
    chk("push_u0", xlog[0], 32'hFE91_2E23);
    chk("push_u1", xlog[1], 32'hFE81_2C23);
    chk("push_u2", xlog[2], 32'hFE11_2A23);
    chk("push_u3", xlog[3], 32'hFF01_0113);
`else
    chk("push_len", 32'(xlog.size()), 32'd1);
    chk("push_pt", xlog[0], 32'h0000_B862);
`endif

    // cm.popret {ra},16
    xlog.delete();
    send(32'h0000_BE42, 1'b1);
    drain();
`ifdef CV32E40X_ZCMP_EN
    chk("popret_len", 32'(xlog.size()), 32'd3);
    chk("popret_u0", xlog[0], 32'h00C1_2083);
    chk("popret_u1", xlog[1], 32'h0101_0113);
    chk("popret_u2", xlog[2], 32'h0000_8067);
`endif

    // Backpressure mid push.
    xlog.delete();
    send(32'h0000_B862, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b0, acc);
    repeat (5) step(1'b1, 32'h00A0_0093, 1'b0, 1'b0, acc);
    drain();
`ifdef CV32E40X_ZCMP_EN
    chk("bp_len", 32'(xlog.size()), 32'd4);
    chk("bp_u1", xlog[1], 32'hFE81_2C23);
    chk("bp_u2", xlog[2], 32'hFE11_2A23);
`endif

    // Illegal rlist=3.
    xlog.delete();
    send(32'h0000_B832, 1'b1);
    drain();
    chk("illegal_len", 32'(xlog.size()), 32'd1);

    // Kill on the 2nd uop of a pop, then restart from IDLE.
    send(32'h0000_BA52, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b0, acc);
    step(1'b1, 32'h00A0_0093, 1'b1, 1'b1, acc);
    send(32'h00A0_0093, 1'b1);
    drain();

    // Longest sequence: popretz rlist 15, spimm 3.
    send(32'h0000_BCFE, 1'b1);
    drain();

    // Reset mid-sequence.
    send(32'h0000_BCFE, 1'b1);
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0, acc);
    @(negedge clk);
    rst = 1'b1;
    #1 chk_reset_state();
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    send(32'h0000_BE42, 1'b1);
    drain();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 9) < 6), rand_instr(), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) == 0), acc);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
